// File: rtl/fb_ddr_scheduler.sv
// fb_ddr_scheduler: buffers 32-bit pixel writes from the rotation stage,
// merges adjacent halves of one 64-bit DDRAM word, issues them under
// ddram_busy back-pressure, and schedules the write/scan-out buffer indices.
module fb_ddr_scheduler #(
    parameter logic [6:0] MEM_BASE = 7'b0010010,
    parameter int         FIFO_AW  = 4
) (
    input  logic             clk_video,
    input  logic             rst_n,
    input  logic             pix_we,
    input  logic [22:0]      pix_addr,
    input  logic [31:0]      pix_data,
    input  logic             frame_start,
    input  logic             fb_vbl,
    input  logic             fb_ll,
    input  logic             ddram_busy,
    output logic             ddram_we,
    output logic [28:0]      ddram_addr,
    output logic [63:0]      ddram_din,
    output logic [7:0]       ddram_be,
    output logic [7:0]       ddram_burstcnt,
    output logic             ddram_rd,
    output logic [1:0]       i_fb,
    output logic [1:0]       o_fb,
    output logic [FIFO_AW:0] fifo_level,
    output logic             overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int LW    = FIFO_AW + 1;
    localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] TWO_LVL  = LW'(2'd2);
    localparam logic [FIFO_AW:0] ZERO_LVL = {LW{1'b0}};

    // Index in {0,1,2} distinct from both arguments; equal arguments step forward by one.
    function automatic logic [1:0] third(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] r;
        if (a == b) begin
            case (a)
                2'd0:    r = 2'd1;
                2'd1:    r = 2'd2;
                default: r = 2'd0;
            endcase
        end else begin
            case ({a, b})
                4'b0001, 4'b0100: r = 2'd2;
                4'b0010, 4'b1000: r = 2'd1;
                default:          r = 2'd0;
            endcase
        end
        return r;
    endfunction

    // FIFO storage: buffer index captured at push time, word/half address, data.
    logic [1:0]  mem_fb   [DEPTH];
    logic [20:0] mem_addr [DEPTH];
    logic [31:0] mem_data [DEPTH];

    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               we_q, we_d;
    logic [28:0]        addr_q, addr_d;
    logic [63:0]        din_q, din_d;
    logic [7:0]         be_q, be_d;
    logic [1:0]         i_fb_q, i_fb_d, o_fb_q, o_fb_d;
    logic               vbl_prev_q, vbl_prev_d;
    logic               vbl_rise_q, vbl_rise_d;
    logic               fs_q, fs_d;

    logic               full_s, push_s, load_s, merge_s;
    logic [1:0]         pop_cnt_s;
    logic [FIFO_AW-1:0] nxt_idx_s;
    logic [1:0]         hd_fb_s, nx_fb_s;
    logic [20:0]        hd_addr_s, nx_addr_s;
    logic [31:0]        hd_data_s, nx_data_s;
    logic               unused_s;

    assign unused_s = &{1'b0, pix_addr[1:0]};

    // Push/pop decisions, merge detection and FIFO bookkeeping.
    always_comb begin
        full_s    = (count_q == FULL_LVL);
        push_s    = pix_we & ~full_s;
        nxt_idx_s = rd_ptr_q + FIFO_AW'(1'b1);
        hd_fb_s   = mem_fb[rd_ptr_q];
        hd_addr_s = mem_addr[rd_ptr_q];
        hd_data_s = mem_data[rd_ptr_q];
        nx_fb_s   = mem_fb[nxt_idx_s];
        nx_addr_s = mem_addr[nxt_idx_s];
        nx_data_s = mem_data[nxt_idx_s];
        // The output register frees up when idle or when its transfer is accepted now.
        load_s    = (~we_q | ~ddram_busy) & (count_q != ZERO_LVL);
        merge_s   = (count_q >= TWO_LVL) && (hd_fb_s == nx_fb_s) &&
                    (hd_addr_s[20:1] == nx_addr_s[20:1]) && (hd_addr_s[0] != nx_addr_s[0]);
        if (load_s) begin
            pop_cnt_s = merge_s ? 2'd2 : 2'd1;
        end else begin
            pop_cnt_s = 2'd0;
        end
        wr_ptr_d   = push_s ? (wr_ptr_q + FIFO_AW'(1'b1)) : wr_ptr_q;
        rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop_cnt_s);
        count_d    = count_q + LW'(push_s) - LW'(pop_cnt_s);
        overflow_d = overflow_q | (pix_we & full_s);
    end

    // Output stage: load a fresh (possibly merged) write, drop strobe when drained, else hold.
    always_comb begin
        we_d   = we_q;
        addr_d = addr_q;
        din_d  = din_q;
        be_d   = be_q;
        if (load_s) begin
            we_d   = 1'b1;
            addr_d = {MEM_BASE, hd_fb_s, hd_addr_s[20:1]};
            if (merge_s) begin
                din_d = hd_addr_s[0] ? {hd_data_s, nx_data_s} : {nx_data_s, hd_data_s};
                be_d  = 8'hFF;
            end else begin
                din_d = {hd_data_s, hd_data_s};
                be_d  = hd_addr_s[0] ? 8'hF0 : 8'h0F;
            end
        end else if (we_q && !ddram_busy) begin
            we_d = 1'b0;
        end else begin
            we_d = we_q;
        end
    end

    // Buffer index scheduling from registered frame_start and vblank-rise events.
    always_comb begin
        i_fb_d     = i_fb_q;
        o_fb_d     = o_fb_q;
        fs_d       = frame_start;
        vbl_prev_d = fb_vbl;
        vbl_rise_d = fb_vbl & ~vbl_prev_q;
        if (fb_ll) begin
            if (fs_q) begin
                i_fb_d = {1'b0, ~i_fb_q[0]};
            end else begin
                i_fb_d = i_fb_q;
            end
            if (vbl_rise_q) begin
                o_fb_d = {1'b0, ~i_fb_q[0]};
            end else begin
                o_fb_d = o_fb_q;
            end
        end else if (fs_q && vbl_rise_q) begin
            // Scan-out takes the finished buffer while writing moves to the free one.
            i_fb_d = third(i_fb_q, o_fb_q);
            o_fb_d = i_fb_q;
        end else if (fs_q) begin
            i_fb_d = third(i_fb_q, o_fb_q);
        end else if (vbl_rise_q) begin
            o_fb_d = third(o_fb_q, i_fb_q);
        end else begin
            i_fb_d = i_fb_q;
            o_fb_d = o_fb_q;
        end
    end

    // FIFO storage write; contents are qualified by the pointers so need no reset.
    always_ff @(posedge clk_video) begin
        if (push_s) begin
            mem_fb[wr_ptr_q]   <= i_fb_q;
            mem_addr[wr_ptr_q] <= pix_addr[22:2];
            mem_data[wr_ptr_q] <= pix_data;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_video or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= {FIFO_AW{1'b0}};
            rd_ptr_q   <= {FIFO_AW{1'b0}};
            count_q    <= {LW{1'b0}};
            overflow_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 29'd0;
            din_q      <= 64'd0;
            be_q       <= 8'd0;
            i_fb_q     <= 2'd0;
            o_fb_q     <= 2'd2;
            vbl_prev_q <= 1'b0;
            vbl_rise_q <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            be_q       <= be_d;
            i_fb_q     <= i_fb_d;
            o_fb_q     <= o_fb_d;
            vbl_prev_q <= vbl_prev_d;
            vbl_rise_q <= vbl_rise_d;
            fs_q       <= fs_d;
        end
    end

    assign ddram_we       = we_q;
    assign ddram_addr     = addr_q;
    assign ddram_din      = din_q;
    assign ddram_be       = be_q;
    assign ddram_burstcnt = 8'd1;
    assign ddram_rd       = 1'b0;
    assign i_fb           = i_fb_q;
    assign o_fb           = o_fb_q;
    assign fifo_level     = count_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_fb_ddr_scheduler.sv
// Testbench for fb_ddr_scheduler: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fb_ddr_scheduler;

    localparam logic [6:0] MEM_BASE = 7'b0010010;
    localparam int         FIFO_AW  = 4;
    localparam int         DEPTH    = 16;

    logic              clk_video = 1'b0;
    logic              rst_n = 1'b0;
    logic              pix_we = 1'b0;
    logic [22:0]       pix_addr = 23'd0;
    logic [31:0]       pix_data = 32'd0;
    logic              frame_start = 1'b0;
    logic              fb_vbl = 1'b0;
    logic              fb_ll = 1'b0;
    logic              ddram_busy = 1'b0;
    logic              ddram_we;
    logic [28:0]       ddram_addr;
    logic [63:0]       ddram_din;
    logic [7:0]        ddram_be;
    logic [7:0]        ddram_burstcnt;
    logic              ddram_rd;
    logic [1:0]        i_fb;
    logic [1:0]        o_fb;
    logic [FIFO_AW:0]  fifo_level;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    fb_ddr_scheduler #(.MEM_BASE(MEM_BASE), .FIFO_AW(FIFO_AW)) dut (
        .clk_video(clk_video), .rst_n(rst_n), .pix_we(pix_we), .pix_addr(pix_addr),
        .pix_data(pix_data), .frame_start(frame_start), .fb_vbl(fb_vbl), .fb_ll(fb_ll),
        .ddram_busy(ddram_busy), .ddram_we(ddram_we), .ddram_addr(ddram_addr),
        .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_burstcnt(ddram_burstcnt),
        .ddram_rd(ddram_rd), .i_fb(i_fb), .o_fb(o_fb), .fifo_level(fifo_level),
        .overflow(overflow)
    );

    always #5 clk_video = ~clk_video;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0]  fb;
        logic [20:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_we;
    logic [28:0] m_addr;
    logic [63:0] m_din;
    logic [7:0]  m_be;
    logic [1:0]  m_ifb, m_ofb;
    logic        m_ovf;
    logic        m_vbl_prev, m_vbl_ev, m_fs_ev;

    function automatic logic [1:0] m_third(input int a, input int b);
        if (a == b) return 2'((a + 1) % 3);
        return 2'(3 - a - b);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0; m_addr = 29'd0; m_din = 64'd0; m_be = 8'd0;
        m_ifb = 2'd0; m_ofb = 2'd2; m_ovf = 1'b0;
        m_vbl_prev = 1'b0; m_vbl_ev = 1'b0; m_fs_ev = 1'b0;
    endtask

    task automatic model_step();
        int   n;
        logic done, do_load, mrg;
        logic [1:0] oi, oo;
        ent_t h, s;
        n = mq.size();
        oi = m_ifb;
        oo = m_ofb;
        done = m_we && !ddram_busy;
        do_load = (!m_we || done) && (n > 0);
        // buffer events sampled on the previous edge take effect now
        if (m_fs_ev && m_vbl_ev && !fb_ll) begin
            m_ifb = m_third(int'(oi), int'(oo));
            m_ofb = oi;
        end else begin
            if (m_fs_ev)  m_ifb = fb_ll ? {1'b0, ~oi[0]} : m_third(int'(oi), int'(oo));
            if (m_vbl_ev) m_ofb = fb_ll ? {1'b0, ~oi[0]} : m_third(int'(oo), int'(oi));
        end
        if (do_load) begin
            h = mq[0];
            mrg = 1'b0;
            if (n >= 2) begin
                s = mq[1];
                mrg = (s.fb == h.fb) && (s.a[20:1] == h.a[20:1]) && (s.a[0] != h.a[0]);
            end
            m_we = 1'b1;
            m_addr = {MEM_BASE, h.fb, h.a[20:1]};
            if (mrg) begin
                m_din = h.a[0] ? {h.d, s.d} : {s.d, h.d};
                m_be = 8'hFF;
                void'(mq.pop_front());
                void'(mq.pop_front());
            end else begin
                m_din = {h.d, h.d};
                m_be = h.a[0] ? 8'hF0 : 8'h0F;
                void'(mq.pop_front());
            end
        end else if (done) begin
            m_we = 1'b0;
        end
        if (pix_we) begin
            if (n == DEPTH) m_ovf = 1'b1;
            else mq.push_back('{fb: oi, a: pix_addr[22:2], d: pix_data});
        end
        m_fs_ev = frame_start;
        m_vbl_ev = fb_vbl && !m_vbl_prev;
        m_vbl_prev = fb_vbl;
    endtask

    // Single compare process: advance the model at each edge, check DUT just after.
    always @(posedge clk_video or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
        #1;
        chk("we",        64'(ddram_we),       64'(m_we));
        chk("addr",      64'(ddram_addr),     64'(m_addr));
        chk("din",       ddram_din,           m_din);
        chk("be",        64'(ddram_be),       64'(m_be));
        chk("level",     64'(fifo_level),     64'(mq.size()));
        chk("overflow",  64'(overflow),       64'(m_ovf));
        chk("i_fb",      64'(i_fb),           64'(m_ifb));
        chk("o_fb",      64'(o_fb),           64'(m_ofb));
        chk("burstcnt",  64'(ddram_burstcnt), 64'd1);
        chk("rd",        64'(ddram_rd),       64'd0);
    end

    task automatic tick();
        @(negedge clk_video);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int busy_pct;
        logic bad;

        repeat (3) tick();
        chk("rst_we",    64'(ddram_we),   64'd0);
        chk("rst_addr",  64'(ddram_addr), 64'd0);
        chk("rst_din",   ddram_din,       64'd0);
        chk("rst_be",    64'(ddram_be),   64'd0);
        chk("rst_i_fb",  64'(i_fb),       64'd0);
        chk("rst_o_fb",  64'(o_fb),       64'd2);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_ovf",   64'(overflow),   64'd0);
        rst_n = 1'b1;
        tick();

        // single write into idle path
        pix_we = 1'b1; pix_addr = 23'h000104; pix_data = 32'h00AABBCC;
        tick();
        pix_we = 1'b0;
        chk("single_lvl1", 64'(fifo_level), 64'd1);
        chk("single_we0",  64'(ddram_we),   64'd0);
        tick();
        chk("single_we",   64'(ddram_we),   64'd1);
        chk("single_addr", 64'(ddram_addr), 64'({7'h12, 2'd0, 20'h00020}));
        chk("single_be",   64'(ddram_be),   64'hF0);
        chk("single_din",  ddram_din,       64'h00AABBCC_00AABBCC);
        tick();
        chk("single_done", 64'(ddram_we),   64'd0);

        // merge behind an in-flight write under back-pressure
        ddram_busy = 1'b1;
        pix_we = 1'b1; pix_addr = 23'h000010; pix_data = 32'h11110000;
        tick();
        pix_addr = 23'h00000C; pix_data = 32'hAAAA000C;
        tick();
        pix_addr = 23'h000008; pix_data = 32'hBBBB0008;
        tick();
        pix_we = 1'b0;
        chk("merge_lvl2",   64'(fifo_level), 64'd2);
        chk("merge_hold_a", 64'(ddram_addr), 64'({7'h12, 2'd0, 20'h00002}));
        chk("merge_hold_b", 64'(ddram_be),   64'h0F);
        ddram_busy = 1'b0;
        tick();
        chk("merge_we",   64'(ddram_we),   64'd1);
        chk("merge_addr", 64'(ddram_addr), 64'({7'h12, 2'd0, 20'h00001}));
        chk("merge_be",   64'(ddram_be),   64'hFF);
        chk("merge_din",  ddram_din,       64'hAAAA000C_BBBB0008);
        chk("merge_lvl0", 64'(fifo_level), 64'd0);
        tick();
        chk("merge_done", 64'(ddram_we),   64'd0);

        // overflow: 20 pushes against a stalled port; the last 3 are dropped
        ddram_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pix_we = 1'b1; pix_addr = 23'(i * 16); pix_data = 32'hC0DE0000 + 32'(i);
            tick();
        end
        pix_we = 1'b0;
        chk("ovf_level", 64'(fifo_level), 64'd16);
        chk("ovf_flag",  64'(overflow),   64'd1);
        ddram_busy = 1'b0;
        n_done = 0;
        for (int i = 0; i < 200; i++) begin
            if (!ddram_we) break;
            n_done++;
            bad = (ddram_din[31:0] > 32'hC0DE0010);
            chk("ovf_dropped_absent", 64'(bad), 64'd0);
            tick();
        end
        chk("ovf_drain_count", 64'(n_done),     64'd17);
        chk("ovf_drain_level", 64'(fifo_level), 64'd0);

        // triple buffering from reset indices
        frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
        chk("tb_fs_i", 64'(i_fb), 64'd1);
        fb_vbl = 1'b1; tick(); tick();
        chk("tb_vbl_o", 64'(o_fb), 64'd0);
        fb_vbl = 1'b0; tick();
        fb_vbl = 1'b1; frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
        chk("tb_sim_i", 64'(i_fb), 64'd2);
        chk("tb_sim_o", 64'(o_fb), 64'd1);
        fb_vbl = 1'b0; tick();

        // mid-operation reset
        ddram_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pix_we = 1'b1; pix_addr = 23'(i * 16 + 4); pix_data = 32'h5A5A0000 + 32'(i);
            tick();
        end
        pix_we = 1'b0;
        chk("mr_pre_we",  64'(ddram_we),   64'd1);
        chk("mr_pre_lvl", 64'(fifo_level), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_we",   64'(ddram_we),   64'd0);
        chk("mr_lvl",  64'(fifo_level), 64'd0);
        chk("mr_i_fb", 64'(i_fb),       64'd0);
        chk("mr_o_fb", 64'(o_fb),       64'd2);
        chk("mr_ovf",  64'(overflow),   64'd0);
        tick();
        ddram_busy = 1'b0;
        rst_n = 1'b1;
        tick();

        // low-latency double buffering
        fb_ll = 1'b1;
        frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
        chk("ll_fs_i", 64'(i_fb), 64'd1);
        fb_vbl = 1'b1; tick(); tick();
        chk("ll_vbl_o", 64'(o_fb), 64'd0);
        fb_vbl = 1'b0; fb_ll = 1'b0; tick();

        // randomized traffic, checked each cycle by the model
        busy_pct = 30;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: busy_pct = 0;
                    1: busy_pct = 30;
                    2: busy_pct = 70;
                    default: busy_pct = 95;
                endcase
            end
            pix_we      = ($urandom_range(0, 99) < 70);
            pix_addr    = 23'($urandom) & 23'h00001F;
            pix_data    = $urandom;
            ddram_busy  = ($urandom_range(0, 99) < busy_pct);
            frame_start = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 5) fb_vbl = ~fb_vbl;
            if ($urandom_range(0, 999) < 5) fb_ll = ~fb_ll;
            tick();
        end
        pix_we = 1'b0; frame_start = 1'b0; ddram_busy = 1'b0;
        repeat (40) tick();
        chk("final_level", 64'(fifo_level), 64'd0);
        chk("final_we",    64'(ddram_we),   64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
